lz_normalizer: RTL and testbench
================================

Name: lz_normalizer

Overview:
- Two-stage pipelined normaliser; sits directly downstream of count_lead_zero and consumes its count.
- Takes a W-bit unsigned word and left-shifts it until the MSB is 1.
- Returns the normalised word, the shift amount and a zero flag.
- Feeds the fixed-point-to-float and magnitude-compare datapaths; valid/ready handshake on both sides.

Parameters:
- W, 8, data width; power of 2, >=2 (same constraint as count_lead_zero).
- TAG_W, 4, width of sideband tag carried alongside each word; >=1.
- W_SH, $clog2(W), shift-count width; left at default.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  W  word to normalise.
- in_tag  input  TAG_W  sideband; passed through unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  W  normalised word.
- out_shift  output  W_SH  number of leading zeroes removed.
- out_zero  output  1  input word was all zeroes.
- out_tag  output  TAG_W  tag of this result.

Behaviour:
- Reset (rst_n low at posedge):
  - s1_valid=0, s2_valid=0.
  - out_valid=0; out_data, out_shift, out_zero, out_tag all 0.
  - In-flight words are discarded, not drained.
- Stage 1 (S1), on accept:
  - Registers in_data and in_tag.
  - Registers lzc = count_lead_zero(in_data) and zero = ~|in_data.
- Stage 2 (S2):
  - Registers data = S1.data << S1.lzc (zeros shifted in, width W, no overflow possible), plus shift, zero and tag.
  - S2 registers drive the outputs directly.
- Zero rule: count_lead_zero returns W-1 (not W) for an all-zero word. When zero=1, S2 forces out_shift=0 and out_data=0, and sets out_zero=1.
- Handshake:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no skid buffer).
- Transfers:
  - Input transfer: in_valid & in_ready at posedge.
  - Output transfer: out_valid & out_ready at posedge.
- Latency and throughput:
  - 2 cycles from input transfer to out_valid with no backpressure.
  - Sustained throughput 1 word per cycle when out_ready is held high.
- Stalls: while out_valid & !out_ready, all outputs hold stable. S1 holds if occupied; S1 may still fill if empty.
- Bubbles: a stage with valid=0 is overwritten freely, and its data content is don't-care except at reset.
- Simultaneous events: S2 output transfer, S1→S2 move and new input transfer all occur in the same cycle when all ready.
- Ordering: strict FIFO; tags emerge in input order, no reordering or drop.
- Capacity: max 2 words in flight. in_ready=0 only when both stages are valid and out_ready=0.
- Output stability: out_valid never deasserts without an output transfer except via reset.
- in_data is ignored when in_valid=0.

Decomposition:
- Shared package lz_pkg:
  - Localparams for default W, TAG_W.
  - Function shift_w(w) returning $clog2(w).
  - Packed struct stage_t {data, shift, zero, tag}, used by both pipeline registers.
- One sub-module: count_lead_zero, instantiated combinationally in front of S1 with W_IN=W.
- Shifter and handshake logic stay inline.

Test Plan:
- W=8, out_ready=1: in 0x01 tag 1 → two cycles later out_data=0x80, out_shift=7, out_zero=0, out_tag=1.
- In 0x80 → out_data=0x80, out_shift=0. In 0x13 → out_data=0x98, out_shift=3.
- In 0x00 → out_zero=1, out_shift=0, out_data=0x00 (checks W-1 count override).
- Back-to-back 0x01, 0x02, 0x04, 0x08, tags 0-3, out_ready held 0 from cycle 2:
  - in_ready drops after exactly 2 accepts; outputs hold 0x80/shift 7 stable.
  - After release, all 4 emerge in order with shifts 7, 6, 5, 4 and no gaps.
- Random in_valid/out_ready toggling, 10k words, scoreboard against reference model: no loss, duplication or reorder; outputs stable during stall.
- rst_n low for one cycle with both stages full and out_ready=0 → next cycle out_valid=0, in_ready=1, outputs 0; next accepted word emerges normally 2 cycles later.

Source files
------------

// File: rtl/lz_pkg.sv
// Shared types and helpers for the leading-zero normaliser datapath.
package lz_pkg;

  localparam int unsigned LzW    = 8;
  localparam int unsigned LzTagW = 4;

  // Width of a shift count able to address every bit position of a w-bit word.
  function automatic int unsigned shift_w(input int unsigned w);
    return $clog2(w);
  endfunction

  localparam int unsigned LzShW = shift_w(LzW);

  // Pipeline register layout at the default widths. The normaliser builds the
  // same layout from its own parameters.
  typedef struct packed {
    logic [LzW-1:0]    data;
    logic [LzShW-1:0]  shift;
    logic              zero;
    logic [LzTagW-1:0] tag;
  } stage_t;

endpackage

// File: rtl/count_lead_zero.sv
// Combinational leading-zero counter. An all-zero word reports W_IN-1, not W_IN,
// so the count always fits in $clog2(W_IN) bits.
module count_lead_zero
  import lz_pkg::*;
#(
  parameter int unsigned W_IN = 8,
  parameter int unsigned W_SH = shift_w(W_IN)
) (
  input  logic [W_IN-1:0] i_data,
  output logic [W_SH-1:0] o_count
);

  // Scan upward from the LSB so the highest set bit wins.
  always_comb begin
    o_count = W_SH'(W_IN - 1);
    for (int i = 0; i < W_IN; i++) begin
      if (i_data[i]) begin
        o_count = W_SH'(W_IN - 1 - i);
      end
    end
  end

endmodule

// File: rtl/lz_normalizer.sv
// Two-stage normaliser: S1 captures the word with its leading-zero count, S2
// applies the shift and drives the outputs. Valid/ready on both sides, no skid.
module lz_normalizer
  import lz_pkg::*;
#(
  parameter int unsigned W     = LzW,
  parameter int unsigned TAG_W = LzTagW,
  parameter int unsigned W_SH  = shift_w(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [W_SH-1:0]  out_shift,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [W-1:0]     data;
    logic [W_SH-1:0]  shift;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } pipe_t;

  logic            r_s1_valid;
  logic            r_s2_valid;
  pipe_t           r_s1;
  pipe_t           r_s2;
  logic [W_SH-1:0] w_lzc;
  logic            w_s1_adv;
  logic            w_s2_adv;
  pipe_t           w_s2_next;

  count_lead_zero #(
    .W_IN (W),
    .W_SH (W_SH)
  ) u_clz (
    .i_data  (in_data),
    .o_count (w_lzc)
  );

  // A stage may load when it is empty or its contents leave this cycle.
  always_comb begin
    w_s2_adv = !r_s2_valid || out_ready;
    w_s1_adv = !r_s1_valid || w_s2_adv;
    in_ready = w_s1_adv;
  end

  // Shift stage; a zero word's W-1 count is discarded so it reports shift 0.
  always_comb begin
    w_s2_next      = r_s1;
    w_s2_next.data = r_s1.data << r_s1.shift;
    if (r_s1.zero) begin
      w_s2_next.data  = '0;
      w_s2_next.shift = '0;
    end
  end

  // Pipeline registers; bubbles may be overwritten, data only loads when valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s1       <= '0;
      r_s2       <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1.data  <= in_data;
          r_s1.shift <= w_lzc;
          r_s1.zero  <= ~|in_data;
          r_s1.tag   <= in_tag;
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2 <= w_s2_next;
        end
      end
    end
  end

  // S2 registers drive the outputs directly.
  always_comb begin
    out_valid = r_s2_valid;
    out_data  = r_s2.data;
    out_shift = r_s2.shift;
    out_zero  = r_s2.zero;
    out_tag   = r_s2.tag;
  end

endmodule

// File: tb/tb_lz_normalizer.sv
// Bench for lz_normalizer: directed latency/zero/backpressure/reset cases and a
// randomized handshake run scored against a behavioural normalisation model.
module tb_lz_normalizer;
  import lz_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [3:0] in_tag = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] out_shift;
  logic       out_zero;
  logic [3:0] out_tag;

  lz_normalizer #(
    .W     (8),
    .TAG_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shift (out_shift),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  int     n_vec = 0;
  int     n_err = 0;
  stage_t q[$];
  logic   in_fire;
  logic   out_fire;
  logic   prev_stall = 1'b0;
  stage_t prev_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: multiply by two until the top bit is set, counting the doublings.
  function automatic stage_t ref_norm(input logic [7:0] d, input logic [3:0] t);
    stage_t s;
    int     x;
    int     n;
    x = int'(d);
    n = 0;
    if (x == 0) begin
      s.data  = '0;
      s.shift = '0;
      s.zero  = 1'b1;
    end else begin
      while (x < 128) begin
        x = x * 2;
        n++;
      end
      s.data  = 8'(x);
      s.shift = 3'(n);
      s.zero  = 1'b0;
    end
    s.tag = t;
    return s;
  endfunction

  function automatic stage_t cur_out();
    return stage_t'({out_data, out_shift, out_zero, out_tag});
  endfunction

  // One clock: drive at the falling edge, sample 1 ns later, score the transfers
  // that the next rising edge will perform.
  task automatic step(input logic v, input logic [7:0] d, input logic [3:0] t,
                      input logic ordy, input logic rst);
    stage_t e;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_tag    = t;
    out_ready = ordy;
    rst_n     = !rst;
    #1;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (prev_stall) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_hold", 32'(cur_out()), 32'(prev_out));
    end
    if (!rst) begin
      check("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
      if (out_fire) begin
        if (q.size() == 0) begin
          check("spurious_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("out_word", 32'(cur_out()), 32'(e));
        end
      end
      if (in_fire) q.push_back(ref_norm(d, t));
      prev_stall = out_valid && !out_ready;
    end else begin
      q.delete();
      prev_stall = 1'b0;
    end
    prev_out = cur_out();
  endtask

  task automatic single(input logic [7:0] d, input logic [3:0] t, input logic [7:0] xd,
                        input logic [2:0] xs, input logic xz);
    step(1'b1, d, t, 1'b1, 1'b0);
    check("single_accept", 32'(in_fire), 32'd1);
    step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
    check("lat_cycle1", 32'(out_valid), 32'd0);
    step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
    check("lat_cycle2", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'(xd));
    check("single_shift", 32'(out_shift), 32'(xs));
    check("single_zero", 32'(out_zero), 32'(xz));
    check("single_tag", 32'(out_tag), 32'(t));
  endtask

  task automatic check_idle_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_outputs", 32'({out_data, out_shift, out_zero, out_tag}), 32'd0);
  endtask

  initial begin
    logic [7:0] words[4];
    int         idx;
    int         got;
    int         first;
    int         last;
    int         n_in;
    int         cyc;
    logic       v;
    logic [7:0] d;

    // Reset state.
    step(1'b0, 8'h00, 4'h0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 4'h0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
    check_idle_reset();

    // Single words, including the all-zero override.
    single(8'h01, 4'd1, 8'h80, 3'd7, 1'b0);
    single(8'h80, 4'd2, 8'h80, 3'd0, 1'b0);
    single(8'h13, 4'd3, 8'h98, 3'd3, 1'b0);
    single(8'h00, 4'd4, 8'h00, 3'd0, 1'b1);

    // Back-to-back with the sink stalled from the third cycle.
    words[0] = 8'h01;
    words[1] = 8'h02;
    words[2] = 8'h04;
    words[3] = 8'h08;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      step(idx < 4, words[idx % 4], 4'(idx), c < 2, 1'b0);
      if (in_fire) idx++;
    end
    check("bp_accepts", 32'(idx), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_hold_data", 32'(out_data), 32'h80);
    check("bp_hold_shift", 32'(out_shift), 32'd7);
    got = 0;
    first = 0;
    last = 0;
    for (int c = 0; c < 12; c++) begin
      step(idx < 4, words[idx % 4], 4'(idx), 1'b1, 1'b0);
      if (in_fire) idx++;
      if (out_fire) begin
        if (got == 0) first = c;
        last = c;
        got++;
      end
    end
    check("bp_drained", 32'(got), 32'd4);
    check("bp_no_gaps", 32'(last - first), 32'd3);

    // Reset with both stages full and the sink stalled.
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 8'(8'h21 + c), 4'(c + 5), 1'b0, 1'b0);
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    step(1'b0, 8'h00, 4'h0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
    check_idle_reset();
    single(8'h40, 4'd9, 8'h80, 3'd1, 1'b0);

    // Randomized handshake run.
    n_in = 0;
    cyc  = 0;
    while ((n_in < 10000 || q.size() != 0) && cyc < 60000) begin
      v = (n_in < 10000) && ($urandom_range(0, 3) != 0);
      d = 8'($urandom) >> $urandom_range(0, 8);
      step(v, d, 4'($urandom), $urandom_range(0, 3) != 0, 1'b0);
      if (in_fire) n_in++;
      cyc++;
    end
    check("rand_words_in", 32'(n_in), 32'd10000);
    check("rand_drained", 32'(q.size()), 32'd0);
    step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
    check("rand_idle", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
